// File: rtl/mask_unit_read_response_collector.sv
// mask_unit_read_response_collector: per-lane response FIFOs with per-requester
// round-robin arbitration into one-entry byte-aligned output registers
module mask_unit_read_response_collector #(
   parameter int LANES = 4,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2,
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [LANES-1:0]                 input_valid,
   output logic [LANES-1:0]                 input_ready,
   input  logic [LANES-1:0][DATA_WIDTH-1:0] input_bits_data,
   input  logic [LANES-1:0][LW-1:0]         input_bits_writeIndex,
   input  logic [LANES-1:0][1:0]            input_bits_dataOffset,
   output logic [LANES-1:0]                 output_valid,
   input  logic [LANES-1:0]                 output_ready,
   output logic [LANES-1:0][DATA_WIDTH-1:0] output_bits_data,
   output logic [LANES-1:0][LW-1:0]         output_bits_readLane,
   output logic                             idle
);
   logic [DATA_WIDTH-1:0] r_data [LANES][FIFO_DEPTH];
   logic [LW-1:0]         r_widx [LANES][FIFO_DEPTH];
   logic [1:0]            r_off  [LANES][FIFO_DEPTH];
   logic [PW-1:0]         r_rd   [LANES];
   logic [PW-1:0]         r_wr   [LANES];
   logic [CW-1:0]         r_cnt  [LANES];
   logic [LW-1:0]         r_rr   [LANES];
   logic [LANES-1:0]      w_push;
   logic [LANES-1:0]      w_deq;
   logic [LANES-1:0]      w_gnt_v;
   logic [LW-1:0]         w_gnt_l [LANES];
   logic [LW-1:0]         w_lane;

   // Ready comes from the registered count only: a full FIFO stays not-ready even while dequeuing.
   always_comb begin
      idle = ~|output_valid;
      for (int i = 0; i < LANES; i++) begin
         input_ready[i] = !reset && (r_cnt[i] != CW'(FIFO_DEPTH));
         w_push[i] = input_valid[i] && input_ready[i];
         idle = idle && (r_cnt[i] == '0);
      end
   end

   // Scan from lowest to highest priority so the highest-priority candidate is written last.
   always_comb begin
      w_deq = '0;
      w_lane = '0;
      for (int r = 0; r < LANES; r++) begin
         w_gnt_v[r] = 1'b0;
         w_gnt_l[r] = '0;
         for (int k = LANES; k >= 1; k--) begin
            w_lane = r_rr[r] + LW'(k);
            if ((!output_valid[r] || output_ready[r]) && r_cnt[w_lane] != '0 &&
                r_widx[w_lane][r_rd[w_lane]] == LW'(r)) begin
               w_gnt_v[r] = 1'b1;
               w_gnt_l[r] = w_lane;
            end
         end
         if (w_gnt_v[r]) w_deq[w_gnt_l[r]] = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LANES; i++) begin
            r_rd[i] <= '0;
            r_wr[i] <= '0;
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (w_push[i]) r_wr[i] <= (r_wr[i] == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr[i] + PW'(1);
            if (w_deq[i]) r_rd[i] <= (r_rd[i] == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd[i] + PW'(1);
            r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_deq[i]);
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < LANES; i++) begin
         if (w_push[i]) begin
            r_data[i][r_wr[i]] <= input_bits_data[i];
            r_widx[i][r_wr[i]] <= input_bits_writeIndex[i];
            r_off[i][r_wr[i]]  <= input_bits_dataOffset[i];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         output_valid <= '0;
         for (int r = 0; r < LANES; r++) begin
            output_bits_data[r]     <= '0;
            output_bits_readLane[r] <= '0;
            r_rr[r]                 <= LW'(LANES - 1);
         end
      end else begin
         for (int r = 0; r < LANES; r++) begin
            if (w_gnt_v[r]) begin
               output_valid[r]         <= 1'b1;
               output_bits_data[r]     <= r_data[w_gnt_l[r]][r_rd[w_gnt_l[r]]] >>
                                          {r_off[w_gnt_l[r]][r_rd[w_gnt_l[r]]], 3'b000};
               output_bits_readLane[r] <= w_gnt_l[r];
               r_rr[r]                 <= w_gnt_l[r];
            end else if (output_ready[r]) begin
               output_valid[r] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_mask_unit_read_response_collector.sv
// tb_mask_unit_read_response_collector: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the collector
module tb_mask_unit_read_response_collector;
   localparam int DEPTH = 2;
   logic              clock = 1'b0;
   logic              reset;
   logic [3:0]        in_valid, in_ready, out_valid, out_ready;
   logic [3:0][31:0]  in_data, out_data;
   logic [3:0][1:0]   in_widx, in_off, out_lane;
   logic              idle;
   int                n_tests = 0;
   int                n_fail = 0;

   typedef struct {
      logic [31:0] d;
      int          w;
      int          o;
   } ent_t;
   ent_t        q[4][$];
   bit          mov[4];
   logic [31:0] md[4];
   int          ml[4];
   int          mrr[4];

   mask_unit_read_response_collector #(.LANES(4), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .input_valid(in_valid), .input_ready(in_ready), .input_bits_data(in_data),
      .input_bits_writeIndex(in_widx), .input_bits_dataOffset(in_off),
      .output_valid(out_valid), .output_ready(out_ready), .output_bits_data(out_data),
      .output_bits_readLane(out_lane), .idle(idle)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
      $fatal(1);
   end

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         mov[i] = 0;
         md[i] = '0;
         ml[i] = 0;
         mrr[i] = 3;
      end
   endtask

   // Advance the reference model by one clock from the current inputs, then clock the DUT.
   task automatic step();
      int  gl[4];
      bit  acc[4];
      bit  deq[4];
      int  l;
      for (int i = 0; i < 4; i++) begin
         acc[i] = in_valid[i] && (q[i].size() < DEPTH);
         deq[i] = 0;
      end
      for (int r = 0; r < 4; r++) begin
         gl[r] = -1;
         if (!mov[r] || out_ready[r])
            for (int k = 1; k <= 4; k++) begin
               l = (mrr[r] + k) % 4;
               if (gl[r] < 0 && q[l].size() > 0 && q[l][0].w == r) gl[r] = l;
            end
      end
      for (int r = 0; r < 4; r++) begin
         if (gl[r] >= 0) begin
            mov[r] = 1;
            md[r] = q[gl[r]][0].d >> (8 * q[gl[r]][0].o);
            ml[r] = gl[r];
            mrr[r] = gl[r];
            deq[gl[r]] = 1;
         end else if (mov[r] && out_ready[r]) begin
            mov[r] = 0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (deq[i]) void'(q[i].pop_front());
         if (acc[i]) q[i].push_back('{in_data[i], int'(in_widx[i]), int'(in_off[i])});
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = '0; in_data = '0; in_widx = '0; in_off = '0; out_ready = '0;
      model_reset();
      @(posedge clock); @(posedge clock); #1;
      n_tests++;
      if (in_ready !== 4'h0) begin n_fail++; $display("FAIL reset_in_ready: got %h need 0", in_ready); end
      n_tests++;
      if (out_valid !== 4'h0 || idle !== 1'b1) begin n_fail++; $display("FAIL reset_valid_idle: got valid=%h idle=%b need 0/1", out_valid, idle); end
      n_tests++;
      if (out_data !== '0 || out_lane !== '0) begin n_fail++; $display("FAIL reset_bits: got data=%h lane=%h need 0", out_data, out_lane); end
      reset = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 4'hF) begin n_fail++; $display("FAIL reset_release_ready: got %h need f", in_ready); end
   endtask

   task automatic test_single();
      out_ready = 4'b0010;
      in_valid = 4'b0100; in_data[2] = 32'hDDCCBBAA; in_widx[2] = 2'd1; in_off[2] = 2'd2;
      step();
      in_valid = '0;
      n_tests++;
      if (out_valid !== 4'h0) begin n_fail++; $display("FAIL single_early: got valid=%h need 0", out_valid); end
      step();
      n_tests++;
      if (out_valid !== 4'b0010 || out_data[1] !== 32'h0000DDCC || out_lane[1] !== 2'd2)
         begin n_fail++; $display("FAIL single_data: got valid=%h data=%h lane=%0d need 2/0000ddcc/2", out_valid, out_data[1], out_lane[1]); end
      n_tests++;
      if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy: got idle=%b need 0", idle); end
      step();
      n_tests++;
      if (idle !== 1'b1 || out_valid !== 4'h0) begin n_fail++; $display("FAIL single_idle: got idle=%b valid=%h need 1/0", idle, out_valid); end
   endtask

   task automatic test_conflict();
      logic [31:0] exp_d [3];
      int          exp_l [3];
      exp_d = '{32'h11110000, 32'h22221111, 32'h44443333};
      exp_l = '{0, 1, 3};
      out_ready = 4'b0001;
      in_valid = 4'b1011; in_widx = '0; in_off = '0;
      in_data[0] = exp_d[0]; in_data[1] = exp_d[1]; in_data[3] = exp_d[2];
      step();
      in_valid = '0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_tests++;
         if (out_valid !== 4'b0001 || out_lane[0] !== 2'(exp_l[k]) || out_data[0] !== exp_d[k])
            begin n_fail++; $display("FAIL conflict_grant%0d: got valid=%h lane=%0d data=%h need 1/%0d/%h", k, out_valid, out_lane[0], out_data[0], exp_l[k], exp_d[k]); end
      end
      step();
      n_tests++;
      if (out_valid !== 4'h0) begin n_fail++; $display("FAIL conflict_drain: got valid=%h need 0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 4'b0000;
      in_widx[1] = 2'd2; in_off[1] = 2'd0;
      for (int c = 0; c < 6; c++) begin
         n_tests++;
         if (in_ready[1] !== (c < 3)) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b need %b", c, in_ready[1], c < 3); end
         if (c >= 2) begin
            n_tests++;
            if (out_valid[2] !== 1'b1 || out_data[2] !== 32'h1000 || out_lane[2] !== 2'd1)
               begin n_fail++; $display("FAIL bp_stable_c%0d: got valid=%b data=%h lane=%0d need 1/00001000/1", c, out_valid[2], out_data[2], out_lane[2]); end
         end
         in_valid = 4'b0010;
         in_data[1] = 32'h1000 + 32'(c < 3 ? c : 3);
         step();
      end
      in_valid = '0;
      out_ready = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (out_valid[2] !== 1'b1 || out_data[2] !== 32'h1000 + 32'(k))
            begin n_fail++; $display("FAIL bp_order%0d: got valid=%b data=%h need 1/%h", k, out_valid[2], out_data[2], 32'h1000 + k); end
         step();
      end
      n_tests++;
      if (out_valid !== 4'h0 || idle !== 1'b1) begin n_fail++; $display("FAIL bp_drain: got valid=%h idle=%b need 0/1", out_valid, idle); end
   endtask

   task automatic test_full_dequeue();
      out_ready = 4'b0000;
      in_widx[0] = 2'd3; in_off[0] = 2'd1;
      for (int c = 0; c < 3; c++) begin
         in_valid = 4'b0001;
         in_data[0] = 32'hA0A0A0A0 + 32'(c);
         step();
      end
      n_tests++;
      if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b need 0", in_ready[0]); end
      out_ready = 4'b1000;
      in_data[0] = 32'h0BAD0BAD;
      n_tests++;
      if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL full_deq_same_cycle: got %b need 0", in_ready[0]); end
      step();
      in_valid = '0;
      n_tests++;
      if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL full_deq_next_cycle: got %b need 1", in_ready[0]); end
      for (int k = 1; k < 3; k++) begin
         n_tests++;
         if (out_valid[3] !== 1'b1 || out_data[3] !== ((32'hA0A0A0A0 + 32'(k)) >> 8) || out_lane[3] !== 2'd0)
            begin n_fail++; $display("FAIL full_data%0d: got valid=%b data=%h lane=%0d", k, out_valid[3], out_data[3], out_lane[3]); end
         step();
      end
      n_tests++;
      if (out_valid !== 4'h0 || idle !== 1'b1) begin n_fail++; $display("FAIL full_drain: got valid=%h idle=%b need 0/1", out_valid, idle); end
   endtask

   task automatic test_parallel();
      out_ready = 4'hF;
      in_off = '0;
      for (int i = 0; i < 4; i++) in_widx[i] = 2'((i + 1) % 4);
      for (int s = 0; s <= 8; s++) begin
         in_valid = (s < 8) ? 4'hF : 4'h0;
         for (int i = 0; i < 4; i++) in_data[i] = {8'(i), 24'(s)};
         step();
         if (s >= 1) begin
            n_tests++;
            if (out_valid !== 4'hF) begin n_fail++; $display("FAIL parallel_valid_s%0d: got %h need f", s, out_valid); end
            for (int r = 0; r < 4; r++) begin
               n_tests++;
               if (out_data[r] !== {8'((r + 3) % 4), 24'(s - 1)} || out_lane[r] !== 2'((r + 3) % 4))
                  begin n_fail++; $display("FAIL parallel_data_s%0d_r%0d: got data=%h lane=%0d need %h/%0d", s, r, out_data[r], out_lane[r], {8'((r + 3) % 4), 24'(s - 1)}, (r + 3) % 4); end
            end
         end
      end
      step();
      n_tests++;
      if (idle !== 1'b1) begin n_fail++; $display("FAIL parallel_idle: got %b need 1", idle); end
   endtask

   task automatic test_random();
      bit exp_idle;
      for (int c = 0; c < 400; c++) begin
         exp_idle = 1;
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (in_ready[i] !== (q[i].size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready_c%0d_l%0d: got %b need %b", c, i, in_ready[i], q[i].size() < DEPTH); end
            if (q[i].size() != 0 || mov[i]) exp_idle = 0;
         end
         for (int r = 0; r < 4; r++) begin
            n_tests++;
            if (out_valid[r] !== mov[r] || (mov[r] && (out_data[r] !== md[r] || out_lane[r] !== 2'(ml[r]))))
               begin n_fail++; $display("FAIL rand_out_c%0d_r%0d: got v=%b d=%h l=%0d need v=%b d=%h l=%0d", c, r, out_valid[r], out_data[r], out_lane[r], mov[r], md[r], ml[r]); end
         end
         n_tests++;
         if (idle !== exp_idle) begin n_fail++; $display("FAIL rand_idle_c%0d: got %b need %b", c, idle, exp_idle); end
         for (int i = 0; i < 4; i++) begin
            in_valid[i] = (c < 370) && ($urandom_range(0, 99) < 60);
            in_data[i] = $urandom;
            in_widx[i] = 2'($urandom_range(0, 3));
            in_off[i] = 2'($urandom_range(0, 3));
            out_ready[i] = (c >= 370) || ($urandom_range(0, 99) < 55);
         end
         step();
      end
      in_valid = '0;
      out_ready = 4'hF;
      for (int c = 0; c < 10; c++) step();
      n_tests++;
      if (idle !== 1'b1) begin n_fail++; $display("FAIL rand_final_idle: got %b need 1", idle); end
   endtask

   task automatic test_midreset();
      out_ready = 4'h0;
      in_off = '0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 4'hF;
         for (int i = 0; i < 4; i++) begin
            in_data[i] = 32'hC0DE0000 + 32'(i * 16 + c);
            in_widx[i] = 2'(i);
         end
         step();
      end
      n_tests++;
      if (out_valid !== 4'hF) begin n_fail++; $display("FAIL midreset_pre: got valid=%h need f", out_valid); end
      reset = 1'b1;
      in_valid = '0;
      model_reset();
      #1;
      n_tests++;
      if (out_valid !== 4'h0 || idle !== 1'b1 || in_ready !== 4'h0)
         begin n_fail++; $display("FAIL midreset_async: got valid=%h idle=%b ready=%h need 0/1/0", out_valid, idle, in_ready); end
      @(posedge clock); @(posedge clock); #1;
      n_tests++;
      if (in_ready !== 4'h0) begin n_fail++; $display("FAIL midreset_hold_ready: got %h need 0", in_ready); end
      reset = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 4'hF) begin n_fail++; $display("FAIL midreset_release: got ready=%h need f", in_ready); end
      out_ready = 4'hF;
      for (int c = 0; c < 3; c++) begin
         step();
         n_tests++;
         if (out_valid !== 4'h0 || idle !== 1'b1) begin n_fail++; $display("FAIL midreset_stale_c%0d: got valid=%h idle=%b need 0/1", c, out_valid, idle); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_conflict();
      test_backpressure();
      test_full_dequeue();
      test_parallel();
      test_random();
      test_midreset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
